multicycle_cpu: RTL and testbench

Parametrised multi-cycle successor to the team's single-cycle 8-bit CPU top. It executes the same 8-bit, four-opcode instruction set (ADD/LW/SW/J) through an explicit state machine. Instruction memory sits behind a request/valid handshake. Data width, PC width and data-memory depth are configurable, and the core adds a self-loop halt, a retire strobe and a debug register read port. It replaces the single-cycle datapath as the core instance under the board top; the clock divider and 7-segment decode stay outside.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/reg_file.sv | 55 +++++
 rtl/multicycle_cpu.sv | 150 +++++++++++++++
 tb/tb_multicycle_cpu.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and helpers for the multi-cycle 8-bit-ISA core.
package cpu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_LW  = 2'b01,
        OP_SW  = 2'b10,
        OP_J   = 2'b11
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam int OP_HI = 7;
    localparam int OP_LO = 6;
    localparam int RS_HI = 5;
    localparam int RS_LO = 4;
    localparam int RT_HI = 3;
    localparam int RT_LO = 2;
    localparam int RD_HI = 1;
    localparam int RD_LO = 0;

    // J with this immediate targets itself and is treated as halt
    localparam logic [1:0] IMM_SELF = 2'b11;

    function automatic logic [31:0] sext2(input logic [1:0] imm);
        return {{30{imm[1]}}, imm};
    endfunction

endpackage

// File: rtl/reg_file.sv
// Four-entry register file: two read ports, one write port and a debug read port.
module reg_file #(
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [1:0]        i_ra,
    input  logic [1:0]        i_rb,
    input  logic [1:0]        i_wa,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_wd,
    input  logic [1:0]        i_dbg_sel,
    output logic [DATA_W-1:0] o_rd_a,
    output logic [DATA_W-1:0] o_rd_b,
    output logic [DATA_W-1:0] o_dbg
);

    logic [DATA_W-1:0] r_reg0, r_reg1, r_reg2, r_reg3;

    function automatic logic [DATA_W-1:0] pick(
        input logic [1:0]        s,
        input logic [DATA_W-1:0] v0,
        input logic [DATA_W-1:0] v1,
        input logic [DATA_W-1:0] v2,
        input logic [DATA_W-1:0] v3
    );
        case (s)
            2'd0:    return v0;
            2'd1:    return v1;
            2'd2:    return v2;
            default: return v3;
        endcase
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_reg0 <= '0;
            r_reg1 <= '0;
            r_reg2 <= '0;
            r_reg3 <= '0;
        end else if (i_we) begin
            case (i_wa)
                2'd0:    r_reg0 <= i_wd;
                2'd1:    r_reg1 <= i_wd;
                2'd2:    r_reg2 <= i_wd;
                default: r_reg3 <= i_wd;
            endcase
        end
    end

    assign o_rd_a = pick(i_ra, r_reg0, r_reg1, r_reg2, r_reg3);
    assign o_rd_b = pick(i_rb, r_reg0, r_reg1, r_reg2, r_reg3);
    assign o_dbg  = pick(i_dbg_sel, r_reg0, r_reg1, r_reg2, r_reg3);

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle ADD/LW/SW/J core: FSM, ALU and data memory inline, register file
// in reg_file. Instructions arrive over a req/valid fetch handshake.
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PC_W       = 8,
    parameter int DMEM_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_valid,
    input  logic [7:0]        imem_data,
    output logic [PC_W-1:0]   pc,
    output logic              halted,
    output logic              retire,
    output logic [PC_W-1:0]   retire_pc,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    state_t            r_state, w_next;
    logic [7:0]        r_ir;
    logic [PC_W-1:0]   r_pc, r_retire_pc, w_pc_next;
    logic              r_imem_req, r_halted, r_retire;
    logic [DATA_W-1:0] r_alu, r_mdr;
    logic [DATA_W-1:0] r_dmem [DMEM_DEPTH];

    opcode_t           w_op;
    logic [1:0]        w_rs, w_rt, w_rd, w_waddr;
    logic [DATA_W-1:0] w_rs_val, w_rt_val, w_alu, w_wdata;
    logic [AW-1:0]     w_daddr;
    logic              w_rf_we, w_dmem_we, w_retire, w_halt;

    assign w_op = opcode_t'(r_ir[OP_HI:OP_LO]);
    assign w_rs = r_ir[RS_HI:RS_LO];
    assign w_rt = r_ir[RT_HI:RT_LO];
    assign w_rd = r_ir[RD_HI:RD_LO];

    // One adder serves both ADD and the LW/SW effective address
    assign w_alu   = w_rs_val + ((w_op == OP_ADD) ? w_rt_val : DATA_W'(sext2(w_rd)));
    assign w_daddr = r_alu[AW-1:0];
    assign w_waddr = (w_op == OP_ADD) ? w_rd : w_rt;
    assign w_wdata = (w_op == OP_ADD) ? r_alu : r_mdr;

    reg_file #(.DATA_W(DATA_W)) u_rf (
        .i_clk     (clk),
        .i_rst     (reset),
        .i_ra      (w_rs),
        .i_rb      (w_rt),
        .i_wa      (w_waddr),
        .i_we      (w_rf_we),
        .i_wd      (w_wdata),
        .i_dbg_sel (dbg_sel),
        .o_rd_a    (w_rs_val),
        .o_rd_b    (w_rt_val),
        .o_dbg     (dbg_data)
    );

    always_comb begin
        w_next    = r_state;
        w_pc_next = r_pc;
        w_rf_we   = 1'b0;
        w_dmem_we = 1'b0;
        w_retire  = 1'b0;
        w_halt    = 1'b0;
        case (r_state)
            S_IDLE:  w_next = S_FETCH;
            S_FETCH: if (imem_valid) w_next = S_EXEC;
            S_EXEC: begin
                case (w_op)
                    OP_ADD:       w_next = S_WB;
                    OP_LW, OP_SW: w_next = S_MEM;
                    default: begin
                        w_retire = 1'b1;
                        if (w_rd == IMM_SELF) begin
                            w_next = S_HALT;
                            w_halt = 1'b1;
                        end else begin
                            w_next    = S_FETCH;
                            w_pc_next = r_pc + PC_W'(1) + PC_W'(sext2(w_rd));
                        end
                    end
                endcase
            end
            S_MEM: begin
                if (w_op == OP_LW) begin
                    w_next = S_WB;
                end else begin
                    w_dmem_we = 1'b1;
                    w_retire  = 1'b1;
                    w_pc_next = r_pc + PC_W'(1);
                    w_next    = S_FETCH;
                end
            end
            S_WB: begin
                w_rf_we   = 1'b1;
                w_retire  = 1'b1;
                w_pc_next = r_pc + PC_W'(1);
                w_next    = S_FETCH;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ir        <= '0;
            r_pc        <= '0;
            r_retire_pc <= '0;
            r_imem_req  <= 1'b0;
            r_halted    <= 1'b0;
            r_retire    <= 1'b0;
            r_alu       <= '0;
            r_mdr       <= '0;
        end else begin
            r_state    <= w_next;
            r_pc       <= w_pc_next;
            r_imem_req <= (w_next == S_FETCH);
            r_retire   <= w_retire;
            if (w_retire) r_retire_pc <= r_pc;
            if (w_halt) r_halted <= 1'b1;
            if (r_state == S_FETCH && imem_valid) r_ir <= imem_data;
            if (r_state == S_EXEC) r_alu <= w_alu;
            if (r_state == S_MEM && w_op == OP_LW) r_mdr <= r_dmem[w_daddr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DMEM_DEPTH; i++) r_dmem[i] <= '0;
        end else if (w_dmem_we) begin
            r_dmem[w_daddr] <= w_rt_val;
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign halted    = r_halted;
    assign retire    = r_retire;
    assign retire_pc = r_retire_pc;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu (PC_W=4 so PC wrap is reachable); the ISA
// cannot make non-zero data from reset, so source registers are forced.
module tb_multicycle_cpu;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       imem_req;
    logic [3:0] imem_addr;
    logic       imem_valid = 1'b1;
    logic [7:0] imem_data;
    logic [3:0] pc;
    logic       halted;
    logic       retire;
    logic [3:0] retire_pc;
    logic [1:0] dbg_sel = 2'd2;
    logic [7:0] dbg_data;

    logic [7:0] prog [16];
    int tests = 0;
    int fails = 0;

    assign imem_data = prog[imem_addr];

    multicycle_cpu #(.DATA_W(8), .PC_W(4), .DMEM_DEPTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .pc         (pc),
        .halted     (halted),
        .retire     (retire),
        .retire_pc  (retire_pc),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_prog();
        foreach (prog[i]) prog[i] = 8'h00;
    endtask

    // Enters at a negedge, leaves at the negedge of the IDLE cycle (s0)
    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    initial begin
        // A: SW R1->[R0+1]; LW R2<-[R0+1]; J halt
        clear_prog();
        prog[0] = 8'h85;
        prog[1] = 8'h49;
        prog[2] = 8'hC3;
        cyc(1);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_retire", 32'(retire), 0);
        chk("rst_retire_pc", 32'(retire_pc), 0);
        chk("rst_dbg", 32'(dbg_data), 0);
        cyc(1);
        reset = 1'b0;
        force dut.u_rf.r_reg1 = 8'h5A;
        chk("idle_req", 32'(imem_req), 0);
        cyc(1);
        chk("fetch_req", 32'(imem_req), 1);
        chk("fetch_addr", 32'(imem_addr), 0);
        cyc(2);
        chk("sw_no_early_retire", 32'(retire), 0);
        cyc(1);
        chk("sw_retire", 32'(retire), 1);
        chk("sw_retire_pc", 32'(retire_pc), 0);
        chk("sw_pc", 32'(pc), 1);
        cyc(3);
        chk("lw_no_early_retire", 32'(retire), 0);
        cyc(1);
        chk("lw_retire", 32'(retire), 1);
        chk("lw_retire_pc", 32'(retire_pc), 1);
        chk("lw_data", 32'(dbg_data), 'h5A);
        cyc(2);
        chk("a_halted", 32'(halted), 1);
        chk("a_halt_retire_pc", 32'(retire_pc), 2);
        chk("a_halt_pc", 32'(pc), 2);

        // B: wait states, ADD wrap, address wrap through two sext paths
        reset = 1'b1;
        release dut.u_rf.r_reg1;
        clear_prog();
        prog[0] = 8'h1B;   // ADD R3 <- R1 + R2
        prog[1] = 8'h9B;   // SW  R2 -> [R1 - 1]   = DMEM[14]
        prog[2] = 8'h4E;   // LW  R3 <- [R0 - 2]   = DMEM[14]
        prog[3] = 8'hC3;
        imem_valid = 1'b0;
        do_reset();
        force dut.u_rf.r_reg1 = 8'hFF;
        force dut.u_rf.r_reg2 = 8'h02;
        dbg_sel = 2'd3;
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk("wait_req", 32'(imem_req), 1);
            chk("wait_pc", 32'(pc), 0);
        end
        imem_valid = 1'b1;
        cyc(2);
        chk("wait_no_early_retire", 32'(retire), 0);
        cyc(1);
        chk("add_retire", 32'(retire), 1);
        chk("add_retire_pc", 32'(retire_pc), 0);
        chk("add_wrap", 32'(dbg_data), 'h01);
        cyc(3);
        chk("sw2_retire_pc", 32'(retire_pc), 1);
        cyc(4);
        chk("lw2_retire", 32'(retire), 1);
        chk("lw2_retire_pc", 32'(retire_pc), 2);
        chk("lw_dmem_depth_m2", 32'(dbg_data), 'h02);

        // C1: J -2 from pc 0 wraps to 15, then sequential 15 -> 0
        reset = 1'b1;
        release dut.u_rf.r_reg1;
        release dut.u_rf.r_reg2;
        clear_prog();
        prog[0] = 8'hC2;
        do_reset();
        cyc(3);
        chk("jback_retire", 32'(retire), 1);
        chk("jback_pc", 32'(pc), 15);
        chk("jback_addr", 32'(imem_addr), 15);
        cyc(3);
        chk("seq_wrap_retire_pc", 32'(retire_pc), 15);
        chk("seq_wrap_pc", 32'(pc), 0);

        // C2: ADD x4, J +1 at pc 4 -> 6, halting J at 6
        clear_prog();
        prog[4] = 8'hC1;
        prog[5] = 8'h85;
        prog[6] = 8'hC3;
        do_reset();
        cyc(15);
        chk("j_retire", 32'(retire), 1);
        chk("j_retire_pc", 32'(retire_pc), 4);
        chk("j_target", 32'(imem_addr), 6);
        chk("j_target_req", 32'(imem_req), 1);
        cyc(2);
        chk("halt_retire", 32'(retire), 1);
        chk("halt_retire_pc", 32'(retire_pc), 6);
        chk("halt_flag", 32'(halted), 1);
        chk("halt_req", 32'(imem_req), 0);
        chk("halt_pc", 32'(pc), 6);
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            chk("halt_hold_req", 32'(imem_req), 0);
            chk("halt_hold_retire", 32'(retire), 0);
            chk("halt_hold_flag", 32'(halted), 1);
        end

        // D: reset while SW is in MEM
        reset = 1'b1;
        clear_prog();
        prog[0] = 8'h85;
        dbg_sel = 2'd2;
        do_reset();
        force dut.u_rf.r_reg1 = 8'h5A;
        cyc(3);
        chk("mem_no_retire", 32'(retire), 0);
        reset = 1'b1;
        #1;
        chk("abort_retire", 32'(retire), 0);
        chk("abort_req", 32'(imem_req), 0);
        chk("abort_pc", 32'(pc), 0);
        release dut.u_rf.r_reg1;
        for (int k = 0; k < 2; k++) begin
            cyc(1);
            chk("abort_hold_retire", 32'(retire), 0);
        end
        prog[0] = 8'h49;   // LW R2 <- [R0+1]
        reset = 1'b0;
        chk("restart_idle_req", 32'(imem_req), 0);
        cyc(1);
        chk("restart_req", 32'(imem_req), 1);
        chk("restart_addr", 32'(imem_addr), 0);
        cyc(3);
        chk("restart_no_early_retire", 32'(retire), 0);
        cyc(1);
        chk("restart_lw_retire", 32'(retire), 1);
        chk("aborted_sw_word", 32'(dbg_data), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
